// File: rtl/peak_rv32im_muldiv.sv
// RV32 M-extension execution unit: fixed-latency multiply and a 32-step restoring divider.
// Divide-by-zero and signed-overflow results are resolved at issue and retired via the MUL path.
module peak_rv32im_muldiv #(
    parameter int unsigned MUL_CYCLES = 1
) (
    input  logic        RST_N,
    input  logic        CLK,
    input  logic        START,
    input  logic        KILL,
    input  logic        INST_MUL,
    input  logic        INST_MULH,
    input  logic        INST_MULHSU,
    input  logic        INST_MULHU,
    input  logic        INST_DIV,
    input  logic        INST_DIVU,
    input  logic        INST_REM,
    input  logic        INST_REMU,
    input  logic [31:0] RS1,
    input  logic [31:0] RS2,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RESULT
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;
    typedef enum logic [2:0] {
        OpMul, OpMulh, OpMulhsu, OpMulhu, OpDiv, OpDivu, OpRem, OpRemu
    } op_e;

    localparam logic [4:0] MulCntInit = 5'(MUL_CYCLES - 1);

    state_e      state_q;
    op_e         op_q;
    logic [31:0] a_q, b_q, rem_q, spec_res_q;
    logic [4:0]  cnt_q;
    logic        special_q, neg_q_q, neg_r_q;

    logic [7:0]  strobes;
    op_e         op_in;
    logic        accept, in_div, in_sdiv, in_rem, div_zero, div_ovf;
    logic [31:0] rs1_mag, rs2_mag, spec_res_in;

    assign strobes = {INST_REMU, INST_REM, INST_DIVU, INST_DIV,
                      INST_MULHU, INST_MULHSU, INST_MULH, INST_MUL};

    always_comb begin
        op_in = OpMul;
        unique case (strobes)
            8'b0000_0001: op_in = OpMul;
            8'b0000_0010: op_in = OpMulh;
            8'b0000_0100: op_in = OpMulhsu;
            8'b0000_1000: op_in = OpMulhu;
            8'b0001_0000: op_in = OpDiv;
            8'b0010_0000: op_in = OpDivu;
            8'b0100_0000: op_in = OpRem;
            8'b1000_0000: op_in = OpRemu;
            default:      op_in = OpMul;
        endcase
    end

    assign accept      = START && (state_q == StIdle) && !KILL && $onehot(strobes);
    assign in_div      = op_in inside {OpDiv, OpDivu, OpRem, OpRemu};
    assign in_sdiv     = (op_in == OpDiv) || (op_in == OpRem);
    assign in_rem      = (op_in == OpRem) || (op_in == OpRemu);
    assign div_zero    = (RS2 == '0);
    assign div_ovf     = in_sdiv && (RS1 == 32'h8000_0000) && (RS2 == 32'hFFFF_FFFF);
    assign rs1_mag     = (in_sdiv && RS1[31]) ? -RS1 : RS1;
    assign rs2_mag     = (in_sdiv && RS2[31]) ? -RS2 : RS2;
    assign spec_res_in = in_rem ? (div_zero ? RS1 : '0)
                                : (div_zero ? 32'hFFFF_FFFF : 32'h8000_0000);

    // 64-bit sign/zero extension gives the same low 64 bits as the 33x33 signed product.
    logic        a_sgn, b_sgn;
    logic [63:0] mul_a, mul_b, prod;
    logic [31:0] mul_res;

    assign a_sgn   = ((op_q == OpMulh) || (op_q == OpMulhsu)) && a_q[31];
    assign b_sgn   = (op_q == OpMulh) && b_q[31];
    assign mul_a   = {{32{a_sgn}}, a_q};
    assign mul_b   = {{32{b_sgn}}, b_q};
    assign prod    = mul_a * mul_b;
    assign mul_res = (op_q == OpMul) ? prod[31:0] : prod[63:32];

    // One restoring step: dividend bits shift out of a_q as quotient bits shift in.
    logic [32:0] rem_sh, diff;
    logic [31:0] q_nx, r_nx, div_res;

    assign rem_sh  = {rem_q, a_q[31]};
    assign diff    = rem_sh - {1'b0, b_q};
    assign q_nx    = {a_q[30:0], ~diff[32]};
    assign r_nx    = diff[32] ? rem_sh[31:0] : diff[31:0];
    assign div_res = ((op_q == OpRem) || (op_q == OpRemu)) ? (neg_r_q ? -r_nx : r_nx)
                                                           : (neg_q_q ? -q_nx : q_nx);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= StIdle;
            op_q       <= OpMul;
            a_q        <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            spec_res_q <= '0;
            cnt_q      <= '0;
            special_q  <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            RESULT     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q       <= op_in;
                        rem_q      <= '0;
                        special_q  <= in_div && (div_zero || div_ovf);
                        spec_res_q <= spec_res_in;
                        neg_q_q    <= in_sdiv && !in_rem && (RS1[31] ^ RS2[31]);
                        neg_r_q    <= in_sdiv && in_rem && RS1[31];
                        if (in_div && !(div_zero || div_ovf)) begin
                            state_q <= StDiv;
                            a_q     <= rs1_mag;
                            b_q     <= rs2_mag;
                            cnt_q   <= 5'd31;
                        end else begin
                            state_q <= StMul;
                            a_q     <= RS1;
                            b_q     <= RS2;
                            cnt_q   <= MulCntInit;
                        end
                    end
                end
                StMul: begin
                    if (KILL) begin
                        state_q <= StIdle;
                    end else if (cnt_q == '0) begin
                        state_q <= StFin;
                        RESULT  <= special_q ? spec_res_q : mul_res;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                StDiv: begin
                    if (KILL) begin
                        state_q <= StIdle;
                    end else begin
                        a_q   <= q_nx;
                        rem_q <= r_nx;
                        if (cnt_q == '0) begin
                            state_q <= StFin;
                            RESULT  <= div_res;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                end
                StFin:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign BUSY = (state_q != StIdle);
    assign DONE = (state_q == StFin);

endmodule
